hazard_ctrl: RTL and testbench

Parametrised hazard-detection and forwarding controller for the 5-stage MIPS pipeline, sitting beside the ID/EX/MEM pipeline registers. It resolves RAW dependencies by forwarding or stalling (selectable mode), flushes IF/ID on taken branches, and freezes the whole pipeline while a load/store in MEM waits on a req/ack memory or UART port. Adds r0 suppression, a memory-wait timeout and a saturating stall-cycle counter.

---
 rtl/hazard_pkg.sv | 27 ++
 rtl/hazard_ctrl_mem_wait_fsm.sv | 80 ++++++++
 rtl/hazard_ctrl.sv | 127 ++++++++++++
 tb/tb_hazard_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared opcodes, forwarding select codes and memory-wait state encoding
// for the pipeline hazard controller.
package hazard_pkg;

    localparam int unsigned OPC_W = 6;
    localparam int unsigned FWD_W = 2;

    localparam logic [OPC_W-1:0] OP_LW  = 6'b100011;
    localparam logic [OPC_W-1:0] OP_SW  = 6'b101011;
    localparam logic [OPC_W-1:0] OP_BEQ = 6'b000100;

    localparam logic [FWD_W-1:0] FWD_RF  = 2'b00;
    localparam logic [FWD_W-1:0] FWD_WB  = 2'b01;
    localparam logic [FWD_W-1:0] FWD_MEM = 2'b10;

    typedef enum logic [1:0] {
        MS_IDLE = 2'd0,
        MS_WAIT = 2'd1,
        MS_DONE = 2'd2,
        MS_ERR  = 2'd3
    } mem_state_e;

    function automatic logic is_ls(input logic [OPC_W-1:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/hazard_ctrl_mem_wait_fsm.sv
// Freezes the pipeline while a MEM-stage load/store handshakes with memory;
// traps into a sticky error state when the transfer never acknowledges.
module mem_wait_fsm
    import hazard_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [OPC_W-1:0] mem_opcode,
    input  logic             mem_ack_i,
    output logic             pstop_o,
    output logic             mem_req_o,
    output logic             timeout_o
);

    localparam int unsigned WC_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned TO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

    mem_state_e      state_q, state_d;
    logic [WC_W-1:0] wait_cnt_q, wait_cnt_d;
    logic            mem_is_ls;

    assign mem_is_ls = is_ls(mem_opcode);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= MS_IDLE;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        pstop_o    = 1'b0;
        mem_req_o  = 1'b0;
        timeout_o  = 1'b0;
        case (state_q)
            MS_IDLE: begin
                pstop_o   = mem_is_ls;
                mem_req_o = mem_is_ls;
                if (mem_is_ls) begin
                    state_d    = MS_WAIT;
                    wait_cnt_d = '0;
                end
            end
            MS_WAIT: begin
                pstop_o    = 1'b1;
                mem_req_o  = 1'b1;
                wait_cnt_d = wait_cnt_q + WC_W'(1);
                // Ack in the final allowed cycle still completes the transfer
                if (mem_ack_i) begin
                    state_d = MS_DONE;
                end else if ((TIMEOUT != 0) && (wait_cnt_q == WC_W'(TO_LAST))) begin
                    state_d = MS_ERR;
                end
            end
            MS_DONE: begin
                state_d = MS_IDLE;
            end
            MS_ERR: begin
                pstop_o   = 1'b1;
                timeout_o = 1'b1;
            end
            default: begin
                state_d = MS_IDLE;
            end
        endcase
        if (!rst) begin
            pstop_o   = 1'b0;
            mem_req_o = 1'b0;
            timeout_o = 1'b0;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// RAW hazard detection, operand forwarding, branch flush and memory-wait
// freeze for a 5-stage MIPS pipeline, with a saturating stall counter.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned REG_W   = 5,
    parameter int unsigned FWD_EN  = 1,
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [OPC_W-1:0] id_opcode,
    input  logic [OPC_W-1:0] ex_opcode,
    input  logic [OPC_W-1:0] mem_opcode,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_rt_is_source,
    input  logic [REG_W-1:0] ex_rs,
    input  logic [REG_W-1:0] ex_rt,
    input  logic [REG_W-1:0] ex_dst_reg,
    input  logic [REG_W-1:0] mem_dst_reg,
    input  logic [REG_W-1:0] wb_dst_reg,
    input  logic             ex_reg_write,
    input  logic             mem_reg_write,
    input  logic             wb_reg_write,
    input  logic             branch_taken_i,
    input  logic             mem_ack_i,
    output logic             mem_req_o,
    output logic             pstop_o,
    output logic             pc_write,
    output logic             if_id_write_en,
    output logic             id_ex_bubble,
    output logic             if_id_flush,
    output logic [FWD_W-1:0] fwd_a_o,
    output logic [FWD_W-1:0] fwd_b_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    logic             ex_dep, mem_dep, hazard;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    mem_wait_fsm #(
        .TIMEOUT (TIMEOUT)
    ) u_mem_wait_fsm (
        .clk        (clk),
        .rst        (rst),
        .mem_opcode (mem_opcode),
        .mem_ack_i  (mem_ack_i),
        .pstop_o    (pstop_o),
        .mem_req_o  (mem_req_o),
        .timeout_o  (timeout_o)
    );

    function automatic logic id_reads(input logic [REG_W-1:0] r, input logic [REG_W-1:0] rs,
                                      input logic [REG_W-1:0] rt, input logic rt_src);
        return (r != '0) && ((r == rs) || (rt_src && (r == rt)));
    endfunction

    function automatic logic [FWD_W-1:0] fwd_sel(input logic [REG_W-1:0] src,
                                                 input logic mem_wr, input logic [REG_W-1:0] mem_dst,
                                                 input logic wb_wr, input logic [REG_W-1:0] wb_dst);
        if (mem_wr && (mem_dst == src) && (src != '0)) return FWD_MEM;
        if (wb_wr && (wb_dst == src) && (src != '0))   return FWD_WB;
        return FWD_RF;
    endfunction

    assign ex_dep  = ex_reg_write && id_reads(ex_dst_reg, id_rs, id_rt, id_rt_is_source);
    assign mem_dep = mem_reg_write && id_reads(mem_dst_reg, id_rs, id_rt, id_rt_is_source);

    // Forwarding covers ALU results; only load-use and branch compares in ID must wait
    always_comb begin
        hazard = 1'b0;
        if (FWD_EN != 0) begin
            hazard = (ex_dep && (ex_opcode == OP_LW)) ||
                     ((id_opcode == OP_BEQ) && ex_dep) ||
                     ((id_opcode == OP_BEQ) && mem_dep && (mem_opcode == OP_LW));
        end else begin
            hazard = ex_dep || mem_dep;
        end
    end

    always_comb begin
        pc_write       = 1'b1;
        if_id_write_en = 1'b1;
        id_ex_bubble   = 1'b0;
        if_id_flush    = 1'b0;
        fwd_a_o        = FWD_RF;
        fwd_b_o        = FWD_RF;
        if (FWD_EN != 0) begin
            fwd_a_o = fwd_sel(ex_rs, mem_reg_write, mem_dst_reg, wb_reg_write, wb_dst_reg);
            fwd_b_o = fwd_sel(ex_rt, mem_reg_write, mem_dst_reg, wb_reg_write, wb_dst_reg);
        end
        if (!rst) begin
            fwd_a_o = FWD_RF;
            fwd_b_o = FWD_RF;
        end else if (pstop_o) begin
            pc_write       = 1'b0;
            if_id_write_en = 1'b0;
        end else if (hazard) begin
            pc_write       = 1'b0;
            if_id_write_en = 1'b0;
            id_ex_bubble   = 1'b1;
        end else begin
            if_id_flush = branch_taken_i;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((pstop_o || id_ex_bubble) && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = rst ? stall_cnt_q : '0;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench: one forwarding-mode and one stall-only instance share stimulus.
module tb_hazard_ctrl;

    localparam int unsigned REG_W = 5;
    localparam int unsigned CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [5:0]       id_opcode, ex_opcode, mem_opcode;
    logic [REG_W-1:0] id_rs, id_rt, ex_rs, ex_rt, ex_dst_reg, mem_dst_reg, wb_dst_reg;
    logic             id_rt_is_source, ex_reg_write, mem_reg_write, wb_reg_write;
    logic             branch_taken_i, mem_ack_i;

    logic             f_req, f_pstop, f_pc, f_ifid, f_bub, f_flush, f_to;
    logic [1:0]       f_fa, f_fb;
    logic [CNT_W-1:0] f_cnt;
    logic             s_req, s_pstop, s_pc, s_ifid, s_bub, s_flush, s_to;
    logic [1:0]       s_fa, s_fb;
    logic [CNT_W-1:0] s_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    int pst_cycles;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_W(REG_W), .FWD_EN(1), .TIMEOUT(4), .CNT_W(CNT_W)) u_fwd (
        .clk(clk), .rst(rst), .id_opcode(id_opcode), .ex_opcode(ex_opcode), .mem_opcode(mem_opcode),
        .id_rs(id_rs), .id_rt(id_rt), .id_rt_is_source(id_rt_is_source), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_dst_reg(ex_dst_reg), .mem_dst_reg(mem_dst_reg), .wb_dst_reg(wb_dst_reg),
        .ex_reg_write(ex_reg_write), .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
        .branch_taken_i(branch_taken_i), .mem_ack_i(mem_ack_i), .mem_req_o(f_req), .pstop_o(f_pstop),
        .pc_write(f_pc), .if_id_write_en(f_ifid), .id_ex_bubble(f_bub), .if_id_flush(f_flush),
        .fwd_a_o(f_fa), .fwd_b_o(f_fb), .timeout_o(f_to), .stall_cnt_o(f_cnt));

    hazard_ctrl #(.REG_W(REG_W), .FWD_EN(0), .TIMEOUT(4), .CNT_W(CNT_W)) u_stall (
        .clk(clk), .rst(rst), .id_opcode(id_opcode), .ex_opcode(ex_opcode), .mem_opcode(mem_opcode),
        .id_rs(id_rs), .id_rt(id_rt), .id_rt_is_source(id_rt_is_source), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_dst_reg(ex_dst_reg), .mem_dst_reg(mem_dst_reg), .wb_dst_reg(wb_dst_reg),
        .ex_reg_write(ex_reg_write), .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
        .branch_taken_i(branch_taken_i), .mem_ack_i(mem_ack_i), .mem_req_o(s_req), .pstop_o(s_pstop),
        .pc_write(s_pc), .if_id_write_en(s_ifid), .id_ex_bubble(s_bub), .if_id_flush(s_flush),
        .fwd_a_o(s_fa), .fwd_b_o(s_fb), .timeout_o(s_to), .stall_cnt_o(s_cnt));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle_inputs();
        id_opcode = 6'd0; ex_opcode = 6'd0; mem_opcode = 6'd0;
        id_rs = '0; id_rt = '0; ex_rs = '0; ex_rt = '0;
        ex_dst_reg = '0; mem_dst_reg = '0; wb_dst_reg = '0;
        id_rt_is_source = 1'b0; ex_reg_write = 1'b0; mem_reg_write = 1'b0; wb_reg_write = 1'b0;
        branch_taken_i = 1'b0; mem_ack_i = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b0;
        tick(); settle();
        check("rst_pc_write", 32'(f_pc), 32'd1);
        check("rst_if_id_en", 32'(f_ifid), 32'd1);
        check("rst_bubble", 32'(f_bub), 32'd0);
        check("rst_pstop", 32'(f_pstop), 32'd0);
        check("rst_stall_cnt", 32'(f_cnt), 32'd0);
        check("rst_timeout", 32'(f_to), 32'd0);
        rst = 1'b1;
        tick();

        // load-use: EX LW r5, ID ADD reads r5
        ex_opcode = 6'b100011; ex_reg_write = 1'b1; ex_dst_reg = 5'd5; id_rs = 5'd5;
        settle();
        check("lu_bubble", 32'(f_bub), 32'd1);
        check("lu_pc_write", 32'(f_pc), 32'd0);
        check("lu_if_id_en", 32'(f_ifid), 32'd0);
        tick();
        mem_opcode = 6'b100011; mem_reg_write = 1'b1; mem_dst_reg = 5'd5;
        ex_opcode = 6'd0; ex_dst_reg = 5'd6; ex_rs = 5'd5; id_rs = 5'd0;
        settle();
        check("lu_fwd_a_mem", 32'(f_fa), 32'd2);
        check("lu_fwd_a_stallmode", 32'(s_fa), 32'd0);
        check("lu_stall_cnt", 32'(f_cnt), 32'd1);
        check("ls_idle_pstop", 32'(f_pstop), 32'd1);
        check("ls_idle_req", 32'(f_req), 32'd1);
        pst_cycles = f_pstop ? 1 : 0;
        tick();
        branch_taken_i = 1'b1;
        settle();
        check("frz_flush", 32'(f_flush), 32'd0);
        check("frz_pc_write", 32'(f_pc), 32'd0);
        if (f_pstop) pst_cycles++;
        tick(); settle();
        if (f_pstop) pst_cycles++;
        tick();
        mem_ack_i = 1'b1;
        settle();
        check("wait_req", 32'(f_req), 32'd1);
        if (f_pstop) pst_cycles++;
        tick();
        mem_ack_i = 1'b0;
        settle();
        check("ls_pstop_cycles", 32'(pst_cycles), 32'd4);
        check("done_pstop", 32'(f_pstop), 32'd0);
        check("done_req", 32'(f_req), 32'd0);
        check("done_flush", 32'(f_flush), 32'd1);
        check("done_flush_stallmode", 32'(s_flush), 32'd1);
        check("done_stall_cnt", 32'(f_cnt), 32'd5);
        idle_inputs();
        tick();

        // branch compare needs EX result; r0 never hazards
        ex_reg_write = 1'b1; ex_dst_reg = 5'd3; id_opcode = 6'b000100; id_rs = 5'd3;
        settle();
        check("beq_ex_bubble", 32'(f_bub), 32'd1);
        ex_dst_reg = 5'd0; id_rs = 5'd0; id_opcode = 6'd0;
        mem_reg_write = 1'b1; mem_dst_reg = 5'd0; ex_rs = 5'd0;
        settle();
        check("r0_bubble", 32'(f_bub), 32'd0);
        check("r0_fwd_a", 32'(f_fa), 32'd0);
        ex_dst_reg = 5'd4; id_rs = 5'd4;
        settle();
        check("alu_dep_fwdmode", 32'(f_bub), 32'd0);
        check("alu_dep_stallmode", 32'(s_bub), 32'd1);
        idle_inputs();
        wb_reg_write = 1'b1; wb_dst_reg = 5'd9; ex_rt = 5'd9;
        settle();
        check("fwd_b_wb", 32'(f_fb), 32'd1);
        mem_reg_write = 1'b1; mem_dst_reg = 5'd9;
        settle();
        check("fwd_b_mem_prio", 32'(f_fb), 32'd2);

        // rt dependency only when rt is actually read
        idle_inputs();
        mem_reg_write = 1'b1; mem_dst_reg = 5'd7; id_rt = 5'd7; id_rs = 5'd1;
        settle();
        check("rt_nosrc_stallmode", 32'(s_bub), 32'd0);
        id_rt_is_source = 1'b1;
        settle();
        check("rt_src_stallmode", 32'(s_bub), 32'd1);
        check("rt_src_pc_write", 32'(s_pc), 32'd0);
        check("rt_src_fwdmode", 32'(f_bub), 32'd0);
        idle_inputs();
        tick();

        // store that never acknowledges
        mem_opcode = 6'b101011;
        settle();
        check("to_idle_req", 32'(f_req), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick(); settle();
            check($sformatf("to_wait%0d_req", i), 32'(f_req), 32'd1);
            check($sformatf("to_wait%0d_to", i), 32'(f_to), 32'd0);
        end
        tick(); settle();
        check("err_timeout", 32'(f_to), 32'd1);
        check("err_pstop", 32'(f_pstop), 32'd1);
        check("err_req", 32'(f_req), 32'd0);
        tick();
        ex_opcode = 6'b100011; ex_reg_write = 1'b1; ex_dst_reg = 5'd5; id_rs = 5'd5;
        branch_taken_i = 1'b1;
        settle();
        check("err_sticky", 32'(f_to), 32'd1);
        check("err_no_bubble", 32'(f_bub), 32'd0);
        check("err_no_flush", 32'(f_flush), 32'd0);
        rst = 1'b0;
        settle();
        check("rstlow_pc_write", 32'(f_pc), 32'd1);
        check("rstlow_timeout", 32'(f_to), 32'd0);
        tick();
        rst = 1'b1;
        idle_inputs();
        settle();
        check("postrst_timeout", 32'(f_to), 32'd0);
        check("postrst_pstop", 32'(f_pstop), 32'd0);
        check("postrst_stall_cnt", 32'(f_cnt), 32'd0);

        // ack in last allowed WAIT cycle wins over timeout
        mem_opcode = 6'b100011;
        tick(); tick(); tick(); tick();
        mem_ack_i = 1'b1;
        settle();
        check("lastwait_pstop", 32'(f_pstop), 32'd1);
        tick();
        mem_ack_i = 1'b0;
        settle();
        check("ackwin_pstop", 32'(f_pstop), 32'd0);
        check("ackwin_timeout", 32'(f_to), 32'd0);
        tick(); settle();
        check("b2b_idle_pstop", 32'(f_pstop), 32'd1);
        check("b2b_idle_req", 32'(f_req), 32'd1);
        tick(); settle();
        check("b2b_wait_req", 32'(f_req), 32'd1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        mem_opcode = 6'd0;
        settle();
        check("midwait_rst_req", 32'(f_req), 32'd0);
        check("midwait_rst_pstop", 32'(f_pstop), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
